mcore_dispatch: RTL and testbench

Parametrised N-channel instruction dispatch core, the successor to the fixed three-channel core. Each channel posts one instruction with a start pulse into a single-entry pending slot. A round-robin arbiter issues one pending instruction per cycle into a two-stage execute pipeline. That pipeline shares a register file and data memory across all channels and returns a per-channel done pulse.

---
 rtl/mcore_dispatch_if.sv | 31 +++
 rtl/mcore_dispatch.sv | 190 +++++++++++++++++++
 tb/tb_mcore_dispatch.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mcore_dispatch_if.sv
// rtl/mcore_dispatch_if.sv - channel post / retire bundle between a host and mcore_dispatch
interface mcore_dispatch_if #(
  parameter int NCH    = 3,
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
);
  localparam int INSTR_W = 4 + 2*REG_AW + MEM_AW + DATA_W;
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]         start;
  logic [NCH*INSTR_W-1:0] instr;
  logic [NCH-1:0]         busy;
  logic [NCH-1:0]         drop;
  logic [NCH-1:0]         done;
  logic                   out_valid;
  logic [CH_W-1:0]        out_ch;
  logic [DATA_W-1:0]      reg_out;
  logic [DATA_W-1:0]      mem_out;
  logic                   err;

  modport master (
    output start, instr,
    input  busy, drop, done, out_valid, out_ch, reg_out, mem_out, err
  );

  modport slave (
    input  start, instr,
    output busy, drop, done, out_valid, out_ch, reg_out, mem_out, err
  );
endinterface

// File: rtl/mcore_dispatch.sv
// rtl/mcore_dispatch.sv - N-channel instruction dispatch core with shared two-stage execute pipeline
// MCORE_DISPATCH_PRIO_EN: fixed lowest-index priority instead of round-robin arbitration
module mcore_dispatch #(
  parameter int NCH    = 3,
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic            clk,
  input  logic            rst,
  mcore_dispatch_if.slave bus
);
  localparam int INSTR_W = 4 + 2*REG_AW + MEM_AW + DATA_W;
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NREG    = 1 << REG_AW;
  localparam int NMEM    = 1 << MEM_AW;

  typedef logic [INSTR_W-1:0] instr_t;

  logic [NCH-1:0]    pend_q, pend_d, busy_q, busy_d, drop_q, drop_d, done_q, done_d;
  instr_t            slot_q [NCH];
  instr_t            slot_d [NCH];
  logic              ex_valid_q, ex_valid_d;
  logic [CH_W-1:0]   ex_ch_q, ex_ch_d;
  instr_t            ex_instr_q, ex_instr_d;
  logic              out_valid_q, out_valid_d, err_q, err_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [DATA_W-1:0] reg_out_q, reg_out_d, mem_out_q, mem_out_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [DATA_W-1:0] mem_q [NMEM];

  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
`ifndef MCORE_DISPATCH_PRIO_EN
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CH_W-1:0]   rr_idx;
`endif

  // Arbiter only sees instructions that are pending, not those already issued.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
`ifdef MCORE_DISPATCH_PRIO_EN
    for (int i = 0; i < NCH; i++) begin
      if (!gnt_vld && pend_q[i]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(i);
      end
    end
`else
    rr_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      rr_idx = CH_W'((int'(last_grant_q) + 1 + i) % NCH);
      if (!gnt_vld && pend_q[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = rr_idx;
      end
    end
`endif
  end

  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs;
  logic [MEM_AW-1:0] addr;
  logic [DATA_W-1:0] imm, rd_v, rs_v, m_v, res;
  logic              wr_rd, mem_we, illegal;

  assign {op, rd, rs, addr, imm} = ex_instr_q;
  assign rd_v = rf_q[rd];
  assign rs_v = rf_q[rs];
  assign m_v  = mem_q[addr];

  always_comb begin
    res     = '0;
    wr_rd   = 1'b0;
    mem_we  = 1'b0;
    illegal = 1'b0;
    case (op)
      4'd0:    res = '0;
      4'd1:    begin res = imm;         wr_rd = 1'b1; end
      4'd2:    begin res = rd_v + rs_v; wr_rd = 1'b1; end
      4'd3:    begin res = rd_v - rs_v; wr_rd = 1'b1; end
      4'd4:    begin res = rd_v & rs_v; wr_rd = 1'b1; end
      4'd5:    begin res = rd_v | rs_v; wr_rd = 1'b1; end
      4'd6:    begin res = rd_v ^ rs_v; wr_rd = 1'b1; end
      4'd7:    begin res = m_v;         wr_rd = 1'b1; end
      4'd8:    mem_we = 1'b1;
      4'd9:    begin res = rs_v;        wr_rd = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    pend_d      = pend_q;
    busy_d      = busy_q;
    slot_d      = slot_q;
    drop_d      = '0;
    done_d      = '0;
    rf_d        = rf_q;
    ex_valid_d  = gnt_vld;
    ex_ch_d     = gnt_ch;
    ex_instr_d  = slot_q[gnt_ch];
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    out_ch_d    = out_ch_q;
    reg_out_d   = reg_out_q;
    mem_out_d   = mem_out_q;
`ifndef MCORE_DISPATCH_PRIO_EN
    last_grant_d = gnt_vld ? gnt_ch : last_grant_q;
`endif
    if (gnt_vld) pend_d[gnt_ch] = 1'b0;
    if (ex_valid_q) begin
      done_d[ex_ch_q] = 1'b1;
      busy_d[ex_ch_q] = 1'b0;
      out_valid_d     = 1'b1;
      err_d           = illegal;
      out_ch_d        = ex_ch_q;
      reg_out_d       = wr_rd ? res : rd_v;
      mem_out_d       = mem_we ? rd_v : m_v;
      if (wr_rd) rf_d[rd] = res;
    end
    // A retiring channel already shows busy_q=0 to a start one cycle later, never in the same edge.
    for (int c = 0; c < NCH; c++) begin
      if (bus.start[c]) begin
        if (busy_q[c]) begin
          drop_d[c] = 1'b1;
        end else begin
          pend_d[c] = 1'b1;
          busy_d[c] = 1'b1;
          slot_d[c] = bus.instr[c*INSTR_W +: INSTR_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      busy_q      <= '0;
      drop_q      <= '0;
      done_q      <= '0;
      slot_q      <= '{default: '0};
      rf_q        <= '{default: '0};
      ex_valid_q  <= 1'b0;
      ex_ch_q     <= '0;
      ex_instr_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      out_ch_q    <= '0;
      reg_out_q   <= '0;
      mem_out_q   <= '0;
`ifndef MCORE_DISPATCH_PRIO_EN
      last_grant_q <= CH_W'(NCH - 1);
`endif
    end else begin
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      done_q      <= done_d;
      slot_q      <= slot_d;
      rf_q        <= rf_d;
      ex_valid_q  <= ex_valid_d;
      ex_ch_q     <= ex_ch_d;
      ex_instr_q  <= ex_instr_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      out_ch_q    <= out_ch_d;
      reg_out_q   <= reg_out_d;
      mem_out_q   <= mem_out_d;
`ifndef MCORE_DISPATCH_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Data memory keeps its contents across reset; a squashed store must not land.
  always_ff @(posedge clk) begin
    if (!rst && ex_valid_q && mem_we) mem_q[addr] <= rd_v;
  end

  assign bus.busy      = busy_q;
  assign bus.drop      = drop_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.reg_out   = reg_out_q;
  assign bus.mem_out   = mem_out_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mcore_dispatch.sv
// tb/tb_mcore_dispatch.sv - cycle-table and directed-sequence bench for mcore_dispatch
module tb_mcore_dispatch;
  localparam int NCH = 3, DATA_W = 8, REG_AW = 4, MEM_AW = 8;
  localparam int IW  = 4 + 2*REG_AW + MEM_AW + DATA_W;
  localparam logic [IW-1:0] Z = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcore_dispatch_if #(.NCH(NCH), .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) bus ();
  mcore_dispatch #(.NCH(NCH), .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic          rst;
    logic [2:0]    st;
    logic [IW-1:0] i0, i1, i2;
    logic [2:0]    busy, drop, done;
    logic          ov;
    logic [1:0]    och;
    logic          err;
    logic [7:0]    rout, mout;
    logic          mchk;
  } vec_t;

  vec_t vq[$];
  int   npass = 0, ntot = 0;
  logic [28:0] act, exp_v;
  int   fd0, fd1, drop0_k;

  function automatic logic [IW-1:0] ins(input int op, input int rd, input int rs, input int ad, input int im);
    return {4'(op), 4'(rd), 4'(rs), 8'(ad), 8'(im)};
  endfunction

  task automatic add(input logic r, input logic [2:0] st, input logic [IW-1:0] a, input logic [IW-1:0] b,
                     input logic [IW-1:0] c, input logic [2:0] bu, input logic [2:0] dr, input logic [2:0] dn,
                     input logic ov, input logic [1:0] oc, input logic er, input logic [7:0] ro,
                     input logic [7:0] mo, input logic mk);
    vec_t v;
    v = '{r, st, a, b, c, bu, dr, dn, ov, oc, er, ro, mo, mk};
    vq.push_back(v);
  endtask

  task automatic check_vec(input int idx, input logic [28:0] a, input logic [28:0] e);
    ntot++;
    if (a !== e) $display("FAIL vec[%0d] {busy,drop,done,ov,och,err,reg,mem} got=%h want=%h", idx, a, e);
    else npass++;
  endtask

  task automatic check_int(input string name, input int a, input int e);
    ntot++;
    if (a != e) $display("FAIL %s got=%0d want=%0d", name, a, e);
    else npass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = '0;
    bus.instr = '0;

    add(1, 0, Z, Z, Z, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(1, 0, Z, Z, Z, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    // ch0 LDI r1=05: two-cycle latency, busy drops with done
    add(0, 3'b001, ins(1, 1, 0, 0, 8'h05), Z, Z, 3'b001, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b001, 0, 0,      0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b001, 1, 0, 0, 8'h05, 8'h00, 0);
    add(0, 0, Z, Z, Z, 3'b000, 0, 0,      0, 0, 0, 8'h05, 8'h00, 0);
    // Reset, then three simultaneous starts, then ADD posted in ch0's done cycle
    add(1, 0, Z, Z, Z, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 3'b111, ins(1, 2, 0, 0, 8'hFF), ins(1, 3, 0, 0, 8'h01), ins(0, 0, 0, 0, 0),
        3'b111, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b111, 0, 0,      0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b110, 0, 3'b001, 1, 0, 0, 8'hFF, 8'h00, 0);
    add(0, 3'b001, ins(2, 2, 3, 0, 0), Z, Z, 3'b101, 0, 3'b010, 1, 1, 0, 8'h01, 8'h00, 0);
    add(0, 0, Z, Z, Z, 3'b001, 0, 3'b100, 1, 2, 0, 8'h00, 8'h00, 0);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b001, 1, 0, 0, 8'h00, 8'h00, 0);
    add(0, 0, Z, Z, Z, 3'b000, 0, 0,      0, 0, 0, 8'h00, 8'h00, 0);
    // ch1 LDI r1=5A, ST r1->[10]; ch2 LD r4<-[10] executes right behind the store
    add(0, 3'b010, Z, ins(1, 1, 0, 8'h10, 8'h5A), Z, 3'b010, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 0, Z, Z, Z, 3'b010, 0, 0,      0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b010, 1, 1, 0, 8'h5A, 8'h00, 0);
    add(0, 3'b010, Z, ins(8, 1, 0, 8'h10, 0), Z, 3'b010, 0, 0, 0, 1, 0, 8'h5A, 8'h00, 0);
    add(0, 3'b100, Z, Z, ins(7, 4, 0, 8'h10, 0), 3'b110, 0, 0, 0, 1, 0, 8'h5A, 8'h00, 0);
    add(0, 0, Z, Z, Z, 3'b100, 0, 3'b010, 1, 1, 0, 8'h5A, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b100, 1, 2, 0, 8'h5A, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 0,      0, 2, 0, 8'h5A, 8'h5A, 1);
    // ch0 double start: second is dropped, MOV r6<-r5 shows the first value survived
    add(0, 3'b001, ins(1, 5, 0, 8'h10, 8'h33), Z, Z, 3'b001, 0, 0, 0, 2, 0, 8'h5A, 8'h5A, 1);
    add(0, 3'b001, ins(1, 5, 0, 8'h10, 8'h44), Z, Z, 3'b001, 3'b001, 0, 0, 2, 0, 8'h5A, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b001, 1, 0, 0, 8'h33, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 0,      0, 0, 0, 8'h33, 8'h5A, 1);
    add(0, 3'b001, ins(9, 6, 5, 8'h10, 0), Z, Z, 3'b001, 0, 0, 0, 0, 0, 8'h33, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b001, 0, 0,      0, 0, 0, 8'h33, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b001, 1, 0, 0, 8'h33, 8'h5A, 1);
    // Illegal opcode F on ch2 with rd=r1: err with done, r1 untouched
    add(0, 3'b100, Z, Z, ins(15, 1, 0, 8'h10, 8'h77), 3'b100, 0, 0, 0, 0, 0, 8'h33, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b100, 0, 0,      0, 0, 0, 8'h33, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b100, 1, 2, 1, 8'h5A, 8'h5A, 1);
    add(0, 3'b001, ins(9, 7, 1, 8'h10, 0), Z, Z, 3'b001, 0, 0, 0, 2, 0, 8'h5A, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b001, 0, 0,      0, 2, 0, 8'h5A, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b001, 1, 0, 0, 8'h5A, 8'h5A, 1);
    // Reset one cycle after a start: squashed, start during reset ignored, r1 cleared, memory kept
    add(0, 3'b001, ins(1, 1, 0, 8'h10, 8'h99), Z, Z, 3'b001, 0, 0, 0, 0, 0, 8'h5A, 8'h5A, 1);
    add(1, 3'b010, Z, ins(1, 2, 0, 0, 8'h11), Z, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 0,      0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 0,      0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 3'b001, ins(9, 7, 1, 8'h10, 0), Z, Z, 3'b001, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b001, 0, 0,      0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 3'b001, 1, 0, 0, 8'h00, 8'h5A, 1);
    add(0, 0, Z, Z, Z, 3'b000, 0, 0,      0, 0, 0, 8'h00, 8'h5A, 1);

    for (int k = 0; k < vq.size(); k++) begin
      rst       = vq[k].rst;
      bus.start = vq[k].st;
      bus.instr = {vq[k].i2, vq[k].i1, vq[k].i0};
      @(posedge clk);
      #1;
      act   = {bus.busy, bus.drop, bus.done, bus.out_valid, bus.out_ch, bus.err, bus.reg_out,
               vq[k].mchk ? bus.mem_out : 8'h00};
      exp_v = {vq[k].busy, vq[k].drop, vq[k].done, vq[k].ov, vq[k].och, vq[k].err, vq[k].rout,
               vq[k].mchk ? vq[k].mout : 8'h00};
      check_vec(k, act, exp_v);
    end

    // ch0 last granted; ch0 and ch1 posted together, ch0 re-posted every cycle afterwards
    rst = 1'b0;
    fd0 = -1;
    fd1 = -1;
    drop0_k = -1;
    for (int k = 0; k < 8; k++) begin
      bus.start = (k == 0) ? 3'b011 : 3'b001;
      bus.instr = {Z, ins(1, 9, 0, 0, 8'h21), ins(1, 8, 0, 0, 8'h20)};
      @(posedge clk);
      #1;
      if (bus.done[1] && fd1 < 0) fd1 = k;
      if (bus.done[0] && fd0 < 0) fd0 = k;
      if (bus.drop[0] && drop0_k < 0) drop0_k = k;
    end
    bus.start = '0;
    repeat (4) @(posedge clk);
`ifdef MCORE_DISPATCH_PRIO_EN
    check_int("prio_ch0_first_done", fd0, 2);
    check_int("prio_ch1_first_done", fd1, 3);
`else
    check_int("rr_ch1_first_done", fd1, 2);
    check_int("rr_ch0_first_done", fd0, 3);
`endif
    check_int("restart_ch0_first_drop", drop0_k, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
